// File: rtl/mux_2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin output arbiter.
// Used by its interface, the arbiter itself and the bench.
package mux_2_arb_pkg;

  typedef logic src_t;

  localparam src_t SRC_REQ0 = 1'b0;
  localparam src_t SRC_REQ1 = 1'b1;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/mux_2_rr_arbiter_if.sv
// Handshake bundle for the arbiter: two valid/ready requesters in,
// one registered valid/ready channel out.
interface mux_2_rr_arbiter_if
  import mux_2_arb_pkg::*;
#(
  parameter int N = 64
);

  logic         i_valid0;
  logic [N-1:0] i_data0;
  logic         o_ready0;
  logic         i_valid1;
  logic [N-1:0] i_data1;
  logic         o_ready1;
  logic         o_valid;
  logic [N-1:0] o_data;
  src_t         o_src;
  logic         i_ready;

  // The arbiter is the slave of this bundle; producers/consumer form the master.
  modport slave (
    input  i_valid0, i_data0, i_valid1, i_data1, i_ready,
    output o_ready0, o_ready1, o_valid, o_data, o_src
  );

  modport master (
    output i_valid0, i_data0, i_valid1, i_data1, i_ready,
    input  o_ready0, o_ready1, o_valid, o_data, o_src
  );

endinterface

// File: rtl/mux_2.sv
// Plain two-input N-bit multiplexer; i_sel=0 picks i_d0, i_sel=1 picks i_d1.
module mux_2 #(
  parameter int N = 64
) (
  input  logic [N-1:0] i_d0,
  input  logic [N-1:0] i_d1,
  input  logic         i_sel,
  output logic [N-1:0] o_y
);

  assign o_y = i_sel ? i_d1 : i_d0;

endmodule

// File: rtl/mux_2_rr_arbiter.sv
// Round-robin arbiter sharing one registered output channel between two
// valid/ready requesters; sustains one beat per cycle.
module mux_2_rr_arbiter
  import mux_2_arb_pkg::*;
#(
  parameter int N = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  mux_2_rr_arbiter_if.slave  bus
);

  state_t       state_q, state_d;
  logic [N-1:0] data_q,  data_d;
  src_t         src_q,   src_d;
  src_t         ptr_q,   ptr_d;

  logic         free;
  logic         grant_vld;
  src_t         grant;
  logic         accept;
  logic         ready0;
  logic         ready1;
  logic [N-1:0] mux_out;

  mux_2 #(.N(N)) u_mux (
    .i_d0  (bus.i_data0),
    .i_d1  (bus.i_data1),
    .i_sel (grant),
    .o_y   (mux_out)
  );

  always_comb begin
    state_d   = state_q;
    data_d    = data_q;
    src_d     = src_q;
    ptr_d     = ptr_q;
    free      = (state_q == ST_EMPTY) || bus.i_ready;
    grant_vld = bus.i_valid0 || bus.i_valid1;
    grant     = SRC_REQ0;

    // Under contention the requester that did not win last time goes next.
    if (bus.i_valid0 && bus.i_valid1) begin
      grant = src_t'(~ptr_q);
    end else if (bus.i_valid1) begin
      grant = SRC_REQ1;
    end

    accept = i_rst_n && free && grant_vld;
    ready0 = accept && (grant == SRC_REQ0);
    ready1 = accept && (grant == SRC_REQ1);

    if (accept) begin
      state_d = ST_FULL;
      data_d  = mux_out;
      src_d   = grant;
      ptr_d   = grant;
    end else if ((state_q == ST_FULL) && bus.i_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      src_q   <= SRC_REQ0;
      ptr_q   <= SRC_REQ1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      src_q   <= src_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.o_ready0 = ready0;
  assign bus.o_ready1 = ready1;
  assign bus.o_valid  = (state_q == ST_FULL);
  assign bus.o_data   = data_q;
  assign bus.o_src    = src_q;

endmodule
